// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues in-order requests on
// the instruction bus, buffers returned words with their PCs and presents them
// to the IF/ID register. Jumps flush the buffer and discard responses to
// requests that were already granted for the old path.
module inst_fetch #(
  parameter logic [31:0] RST_ADDR = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  // Request and response bookkeeping
  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   pc_last_q, pc_last_d;

  // In-flight PC queue: PCs of granted requests awaiting data
  logic [31:0]   ifq_pc_q [DEPTH];
  logic [AW-1:0] ifq_rd_q, ifq_rd_d;
  logic [AW-1:0] ifq_wr_q, ifq_wr_d;

  // Prefetch buffer of returned {pc, inst} pairs
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];
  logic [AW-1:0] buf_rd_q, buf_rd_d;
  logic [AW-1:0] buf_wr_q, buf_wr_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;

  logic [OW-1:0] occ_s;
  logic          buf_valid_s;
  logic          pop_s;
  logic          req_s;
  logic          hs_s;
  logic          rv_s;
  logic          discard_s;
  logic          push_s;

  // Handshake qualifiers; a jump takes precedence over popping the head
  always_comb begin
    occ_s       = {1'b0, buf_cnt_q} + {1'b0, out_q};
    buf_valid_s = (buf_cnt_q != {CW{1'b0}});
    pop_s       = buf_valid_s & ~hold_i & ~jump_flag_i;
    req_s       = run_q & ((occ_s < OW'(DEPTH)) | ((occ_s == OW'(DEPTH)) & pop_s));
    hs_s        = req_s & ibus_gnt_i;
    rv_s        = ibus_rvalid_i & (out_q != {CW{1'b0}});
    discard_s   = rv_s & ((drop_q != {CW{1'b0}}) | jump_flag_i);
    push_s      = rv_s & ~discard_s;
  end

  // Next-state for PC, counters and queue pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CW'(hs_s) - CW'(rv_s);
    drop_d     = drop_q;
    ifq_rd_d   = ifq_rd_q + AW'(rv_s);
    ifq_wr_d   = ifq_wr_q + AW'(hs_s);
    buf_wr_d   = buf_wr_q + AW'(push_s);
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q;
    pc_last_d  = buf_valid_s ? buf_pc_q[buf_rd_q] : pc_last_q;
    if (jump_flag_i) begin
      // Everything still outstanding after this edge belongs to the old path
      fetch_pc_d = jump_addr_i & 32'hFFFF_FFFC;
      drop_d     = out_q + CW'(hs_s) - CW'(rv_s);
      buf_rd_d   = buf_wr_q;
      buf_cnt_d  = {CW{1'b0}};
    end else begin
      if (hs_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (discard_s) begin
        drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_d = drop_q;
      end
      buf_rd_d  = buf_rd_q + AW'(pop_s);
      buf_cnt_d = buf_cnt_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RST_ADDR;
      out_q      <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
      pc_last_q  <= RST_ADDR;
      ifq_rd_q   <= {AW{1'b0}};
      ifq_wr_q   <= {AW{1'b0}};
      buf_rd_q   <= {AW{1'b0}};
      buf_wr_q   <= {AW{1'b0}};
      buf_cnt_q  <= {CW{1'b0}};
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      pc_last_q  <= pc_last_d;
      ifq_rd_q   <= ifq_rd_d;
      ifq_wr_q   <= ifq_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  // Queue storage; entries are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (hs_s) begin
      ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
    end
    if (push_s) begin
      buf_pc_q[buf_wr_q]   <= ifq_pc_q[ifq_rd_q];
      buf_inst_q[buf_wr_q] <= ibus_rdata_i;
    end
  end

  assign ibus_req_o   = req_s;
  assign ibus_addr_o  = fetch_pc_q;
  assign inst_valid_o = buf_valid_s;
  assign pc_o         = buf_valid_s ? buf_pc_q[buf_rd_q]   : pc_last_q;
  assign inst_o       = buf_valid_s ? buf_inst_q[buf_rd_q] : NOP;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based reference model of the
// fetch front end plus an in-order bus responder with random latency.
module tb_inst_fetch;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold_i = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  inst_fetch #(.RST_ADDR(RST_ADDR), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i(ibus_rdata_i), .pc_o(pc_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] m_infl[$];
  logic [31:0] m_bpc[$];
  logic [31:0] m_binst[$];
  int          m_drop;
  logic [31:0] m_fpc;
  logic [31:0] m_last;
  bit          m_run;

  // Bus responder state
  logic [31:0] bus_addr[$];
  int          bus_rdy[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_infl.delete(); m_bpc.delete(); m_binst.delete();
    bus_addr.delete(); bus_rdy.delete();
    m_drop = 0; m_fpc = RST_ADDR; m_last = RST_ADDR; m_run = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, ibus_req_o},   32'd0);
    check({tag, "_addr"},  ibus_addr_o,           RST_ADDR);
    check({tag, "_pc"},    pc_o,                  RST_ADDR);
    check({tag, "_inst"},  inst_o,                NOP);
    check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
  endtask

  // Assert reset asynchronously mid-cycle, check it, then release on a negedge
  task automatic do_reset();
    @(negedge clk);
    hold_i = 1'b0; jump_flag_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    #1 check_reset_outputs("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_run = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model
  task automatic step(input bit h, input bit jf, input logic [31:0] ja, input bit g,
                      input bit rv_ok, input int lat, input bit spur);
    bit          from_bus, valid, pop, ereq, hs, rve;
    int          n, occ;
    logic [31:0] p, old_fpc;
    @(negedge clk);
    hold_i = h; jump_flag_i = jf; jump_addr_i = ja; ibus_gnt_i = g;
    from_bus = (bus_addr.size() > 0) && (bus_rdy[0] <= cyc) && rv_ok;
    if (from_bus) begin
      ibus_rvalid_i = 1'b1; ibus_rdata_i = bus_addr[0] ^ KEY;
    end else begin
      ibus_rvalid_i = spur && (bus_addr.size() == 0);
      ibus_rdata_i  = $urandom;
    end
    #1;
    n     = m_infl.size();
    occ   = m_bpc.size() + n;
    valid = m_bpc.size() > 0;
    pop   = valid && !h && !jf;
    ereq  = m_run && ((occ < DEPTH) || (occ == DEPTH && pop));
    check("req",   {31'd0, ibus_req_o},   {31'd0, ereq});
    check("addr",  ibus_addr_o,           m_fpc);
    check("valid", {31'd0, inst_valid_o}, {31'd0, valid});
    check("pc",    pc_o,                  valid ? m_bpc[0] : m_last);
    check("inst",  inst_o,                valid ? m_binst[0] : NOP);
    hs  = ereq && g;
    rve = ibus_rvalid_i && (n > 0);
    old_fpc = m_fpc;
    if (valid) m_last = m_bpc[0];
    if (pop) begin
      void'(m_bpc.pop_front()); void'(m_binst.pop_front());
    end
    if (rve) begin
      p = m_infl.pop_front();
      if (m_drop > 0 || jf) begin
        if (!jf) m_drop--;
      end else begin
        m_bpc.push_back(p); m_binst.push_back(ibus_rdata_i);
      end
    end
    if (hs) m_infl.push_back(old_fpc);
    if (jf) begin
      m_bpc.delete(); m_binst.delete();
      m_drop = n + int'(hs) - int'(rve);
      m_fpc  = ja & 32'hFFFF_FFFC;
    end else if (hs) begin
      m_fpc = m_fpc + 32'd4;
    end
    if (from_bus) begin
      void'(bus_addr.pop_front()); void'(bus_rdy.pop_front());
    end
    if (hs) begin
      bus_addr.push_back(old_fpc); bus_rdy.push_back(cyc + lat);
    end
    cyc++;
  endtask

  task automatic random_phase(input int ncyc);
    bit          h, jf, g, rv;
    logic [31:0] ja;
    for (int i = 0; i < ncyc; i++) begin
      h  = ($urandom_range(0, 99) < 30);
      jf = ($urandom_range(0, 99) < 6);
      g  = ($urandom_range(0, 99) < 70);
      rv = ($urandom_range(0, 99) < 70);
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      step(h, jf, ja, g, rv, $urandom_range(1, 3), 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #1 check_reset_outputs("por");
    do_reset();

    // Streaming with single-cycle latency: first word appears on the third step
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
    check("first_valid", {31'd0, inst_valid_o}, 32'd1);
    check("first_pc",    pc_o,                  32'h0000_0000);
    check("first_inst",  inst_o,                32'hA5A5_0000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);

    // Hold while streaming, then release
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);

    // Grant withheld: buffer drains, request address stays put
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);

    // Jump with two requests outstanding (responses held back)
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2, 1'b0);

    // Jump coinciding with grant, response and hold
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);

    // Address wrap at the top of the space
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);

    random_phase(400);

    // Reset mid-stream, then a stray response with nothing outstanding
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
    random_phase(300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
